// File: rtl/kbd_pkg.sv
// Set-2 scan-code constants and the scan-code to 7-bit ASCII lookup used by kbd_ascii_fifo.
package kbd_pkg;

  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CAPS   = 8'h58;
  localparam logic [7:0] SC_SPACE  = 8'h29;
  localparam logic [7:0] SC_ENTER  = 8'h5A;
  localparam logic [7:0] SC_BKSP   = 8'h66;
  localparam logic [7:0] SC_TAB    = 8'h0D;
  localparam logic [7:0] SC_ESC    = 8'h76;

  // Unmapped codes, including the modifier and break prefixes, return NUL.
  function automatic logic [7:0] scan_to_ascii(input logic [7:0] code, input logic upper);
    logic [6:0] base;
    logic [6:0] c;
    base = upper ? 7'h41 : 7'h61;
    c    = 7'h00;
    case (code)
      8'h1C: c = base + 7'd0;
      8'h32: c = base + 7'd1;
      8'h21: c = base + 7'd2;
      8'h23: c = base + 7'd3;
      8'h24: c = base + 7'd4;
      8'h2B: c = base + 7'd5;
      8'h34: c = base + 7'd6;
      8'h33: c = base + 7'd7;
      8'h43: c = base + 7'd8;
      8'h3B: c = base + 7'd9;
      8'h42: c = base + 7'd10;
      8'h4B: c = base + 7'd11;
      8'h3A: c = base + 7'd12;
      8'h31: c = base + 7'd13;
      8'h44: c = base + 7'd14;
      8'h4D: c = base + 7'd15;
      8'h15: c = base + 7'd16;
      8'h2D: c = base + 7'd17;
      8'h1B: c = base + 7'd18;
      8'h2C: c = base + 7'd19;
      8'h3C: c = base + 7'd20;
      8'h2A: c = base + 7'd21;
      8'h1D: c = base + 7'd22;
      8'h22: c = base + 7'd23;
      8'h35: c = base + 7'd24;
      8'h1A: c = base + 7'd25;
      8'h16: c = upper ? 7'h21 : 7'h31;
      8'h1E: c = upper ? 7'h40 : 7'h32;
      8'h26: c = upper ? 7'h23 : 7'h33;
      8'h25: c = upper ? 7'h24 : 7'h34;
      8'h2E: c = upper ? 7'h25 : 7'h35;
      8'h36: c = upper ? 7'h5E : 7'h36;
      8'h3D: c = upper ? 7'h26 : 7'h37;
      8'h3E: c = upper ? 7'h2A : 7'h38;
      8'h46: c = upper ? 7'h28 : 7'h39;
      8'h45: c = upper ? 7'h29 : 7'h30;
      SC_SPACE: c = 7'h20;
      SC_ENTER: c = 7'h0D;
      SC_BKSP:  c = 7'h08;
      SC_TAB:   c = 7'h09;
      SC_ESC:   c = 7'h1B;
      default:  c = 7'h00;
    endcase
    return {1'b0, c};
  endfunction

endpackage

// File: rtl/kbd_ascii_fifo_if.sv
// Keyboard-side and consumer-side handshake bundle of kbd_ascii_fifo.
interface kbd_ascii_fifo_if;
  logic [7:0] scan_code;
  logic       scan_code_ready;
  logic       letter_case;
  logic [7:0] ascii;
  logic       ascii_valid;
  logic       ascii_ready;

  modport master (
    output scan_code, scan_code_ready, letter_case, ascii_ready,
    input  ascii, ascii_valid
  );

  modport slave (
    input  scan_code, scan_code_ready, letter_case, ascii_ready,
    output ascii, ascii_valid
  );
endinterface

// File: rtl/kbd_sync_fifo.sv
// First-word-fall-through synchronous FIFO; head reads as zero while empty.
module kbd_sync_fifo #(
  parameter  int DEPTH  = 16,
  parameter  int WIDTH  = 8,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  output logic [WIDTH-1:0]  rd_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   level
);

  logic [ADDR_W:0]  wr_ptr;
  logic [ADDR_W:0]  rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_rd;
  logic             do_wr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                 (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
  assign level = wr_ptr - rd_ptr;

  // A pop frees the slot the write needs, so full+pop+write is accepted.
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[ADDR_W-1:0]] <= wr_data;
  end

  assign rd_data = empty ? '0 : mem[rd_ptr[ADDR_W-1:0]];

endmodule

// File: rtl/kbd_ascii_fifo.sv
// Scan-code to ASCII lookup stage feeding a FWFT character FIFO with sticky overflow.
// Build option: define KBD_FILTER_NONPRINT_EN to drop unmapped (NUL) characters.
module kbd_ascii_fifo
  import kbd_pkg::*;
#(
  parameter  int DEPTH  = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  kbd_ascii_fifo_if.slave bus,
  output logic [ADDR_W:0] level,
  output logic            overflow,
  input  logic            overflow_clr
);

  logic [7:0] stage_ascii_p1;
  logic       stage_vld_p1;
  logic       wr_req;
  logic       pop;
  logic       full;
  logic       empty;

  // Stage p1: registered lookup result, valid for one cycle per key pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      stage_vld_p1   <= 1'b0;
      stage_ascii_p1 <= '0;
    end else begin
      stage_vld_p1 <= bus.scan_code_ready;
      if (bus.scan_code_ready)
        stage_ascii_p1 <= scan_to_ascii(bus.scan_code, bus.letter_case);
    end
  end

`ifdef KBD_FILTER_NONPRINT_EN
  assign wr_req = stage_vld_p1 && (stage_ascii_p1 != 8'h00);
`else
  assign wr_req = stage_vld_p1;
`endif

  assign pop             = bus.ascii_valid && bus.ascii_ready;
  assign bus.ascii_valid = !empty;

  // Stage p2: FIFO storage, head presented combinationally.
  kbd_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_req),
    .wr_data (stage_ascii_p1),
    .rd_en   (pop),
    .rd_data (bus.ascii),
    .full    (full),
    .empty   (empty),
    .level   (level)
  );

  // A refused write outranks a same-cycle clear.
  always_ff @(posedge clk) begin
    if (reset)
      overflow <= 1'b0;
    else if (wr_req && full && !pop)
      overflow <= 1'b1;
    else if (overflow_clr)
      overflow <= 1'b0;
  end

endmodule

// File: tb/tb_kbd_ascii_fifo.sv
// Directed plus randomized bench for kbd_ascii_fifo against a queue-based character model.
module tb_kbd_ascii_fifo;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = $clog2(DEPTH);

  logic            clk = 1'b0;
  logic            reset;
  logic [ADDR_W:0] level;
  logic            overflow;
  logic            overflow_clr;

  kbd_ascii_fifo_if bus ();

  kbd_ascii_fifo #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .level        (level),
    .overflow     (overflow),
    .overflow_clr (overflow_clr)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  byte unsigned q[$];
  bit          m_stage_vld;
  byte unsigned m_stage;
  bit          m_ovf;

  byte unsigned pool[41] = '{8'h1C,8'h32,8'h21,8'h23,8'h24,8'h2B,8'h34,8'h33,8'h43,8'h3B,
                             8'h42,8'h4B,8'h3A,8'h31,8'h44,8'h4D,8'h15,8'h2D,8'h1B,8'h2C,
                             8'h3C,8'h2A,8'h1D,8'h22,8'h35,8'h1A,8'h16,8'h1E,8'h26,8'h25,
                             8'h2E,8'h36,8'h3D,8'h3E,8'h46,8'h45,8'h29,8'h5A,8'h66,8'h0D,8'h76};

  function automatic byte unsigned ref_ascii(byte unsigned code, bit up);
    byte unsigned letters[26];
    byte unsigned digits[10];
    byte unsigned fixed_code[5];
    byte unsigned fixed_char[5];
    string dl, du;
    letters    = '{8'h1C,8'h32,8'h21,8'h23,8'h24,8'h2B,8'h34,8'h33,8'h43,8'h3B,8'h42,8'h4B,8'h3A,
                   8'h31,8'h44,8'h4D,8'h15,8'h2D,8'h1B,8'h2C,8'h3C,8'h2A,8'h1D,8'h22,8'h35,8'h1A};
    digits     = '{8'h16,8'h1E,8'h26,8'h25,8'h2E,8'h36,8'h3D,8'h3E,8'h46,8'h45};
    fixed_code = '{8'h29,8'h5A,8'h66,8'h0D,8'h76};
    fixed_char = '{8'h20,8'h0D,8'h08,8'h09,8'h1B};
    dl = "1234567890";
    du = "!@#$%^&*()";
    for (int i = 0; i < 26; i++)
      if (code == letters[i]) return (up ? 8'h41 : 8'h61) + 8'(i);
    for (int i = 0; i < 10; i++)
      if (code == digits[i]) return up ? du[i] : dl[i];
    for (int i = 0; i < 5; i++)
      if (code == fixed_code[i]) return fixed_char[i];
    return 8'h00;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    bit pop, wr, full_now, ovf_set;
    if (reset) begin
      q.delete();
      m_stage_vld = 1'b0;
      m_stage     = 8'h00;
      m_ovf       = 1'b0;
    end else begin
      full_now = (q.size() == DEPTH);
      pop      = (q.size() != 0) && bus.ascii_ready;
      wr       = m_stage_vld;
`ifdef KBD_FILTER_NONPRINT_EN
      if (m_stage == 8'h00) wr = 1'b0;
`endif
      ovf_set = wr && full_now && !pop;
      if (pop) void'(q.pop_front());
      if (wr && !ovf_set) q.push_back(m_stage);
      if (ovf_set) m_ovf = 1'b1;
      else if (overflow_clr) m_ovf = 1'b0;
      m_stage_vld = bus.scan_code_ready;
      if (bus.scan_code_ready) m_stage = ref_ascii(bus.scan_code, bus.letter_case);
    end
    @(posedge clk);
    #1;
    chk("ascii_valid", bus.ascii_valid, q.size() != 0);
    chk("ascii", bus.ascii, (q.size() != 0) ? q[0] : 8'h00);
    chk("level", level, q.size());
    chk("overflow", overflow, m_ovf);
  endtask

  task automatic send(byte unsigned code, bit lc);
    bus.scan_code       = code;
    bus.letter_case     = lc;
    bus.scan_code_ready = 1'b1;
    tick();
    bus.scan_code_ready = 1'b0;
  endtask

  initial begin
    reset               = 1'b1;
    overflow_clr        = 1'b0;
    bus.scan_code       = 8'h00;
    bus.scan_code_ready = 1'b0;
    bus.letter_case     = 1'b0;
    bus.ascii_ready     = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("reset_ascii", bus.ascii, 8'h00);
    chk("reset_level", level, 0);

    // Case handling and in-order delivery.
    send(8'h1C, 1'b0);
    send(8'h1C, 1'b1);
    chk("t1_first_latency", bus.ascii, 8'h61);
    tick();
    chk("t1_level2", level, 2);
    bus.ascii_ready = 1'b1;
    tick();
    chk("t1_second", bus.ascii, 8'h41);
    tick();
    bus.ascii_ready = 1'b0;

    send(8'h16, 1'b1);
    send(8'h29, 1'b0);
    send(8'h5A, 1'b0);
    tick();
    chk("t2_bang", bus.ascii, 8'h21);
    bus.ascii_ready = 1'b1;
    tick();
    chk("t2_space", bus.ascii, 8'h20);
    tick();
    chk("t2_enter", bus.ascii, 8'h0D);
    tick();
    bus.ascii_ready = 1'b0;

    // Unmapped code.
    send(8'h07, 1'b0);
    tick();
`ifdef KBD_FILTER_NONPRINT_EN
    chk("t3_filtered_level", level, 0);
`else
    chk("t3_nul_valid", bus.ascii_valid, 1);
    chk("t3_nul_ascii", bus.ascii, 8'h00);
`endif
    bus.ascii_ready = 1'b1;
    tick();
    bus.ascii_ready = 1'b0;

    // Overflow on DEPTH+1 writes, then clear.
    for (int i = 0; i < DEPTH + 1; i++) send(pool[i], i[0]);
    tick();
    tick();
    chk("t4_full_level", level, DEPTH);
    chk("t4_overflow", overflow, 1);
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    chk("t4_cleared", overflow, 0);

    // Full FIFO with simultaneous pop and write.
    send(8'h35, 1'b0);
    bus.ascii_ready = 1'b1;
    tick();
    bus.ascii_ready = 1'b0;
    chk("t5_level", level, DEPTH);
    chk("t5_no_overflow", overflow, 0);
    bus.ascii_ready = 1'b1;
    for (int i = 0; i < DEPTH + 2; i++) tick();
    bus.ascii_ready = 1'b0;

    // Reset with contents and a pending stage entry.
    send(8'h1C, 1'b0);
    send(8'h32, 1'b0);
    send(8'h21, 1'b0);
    tick();
    send(8'h23, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_valid", bus.ascii_valid, 0);
    chk("t6_level", level, 0);
    chk("t6_ascii", bus.ascii, 8'h00);
    tick();
    chk("t6_stage_dropped", level, 0);
    reset = 1'b1;
    bus.scan_code = 8'h24;
    bus.scan_code_ready = 1'b1;
    tick();
    bus.scan_code_ready = 1'b0;
    reset = 1'b0;
    tick();
    tick();
    chk("t6_coincident_dropped", level, 0);

    // Randomized traffic, with stall phases to reach full.
    for (int i = 0; i < 600; i++) begin
      bus.scan_code_ready = ($urandom_range(2) != 0);
      bus.scan_code       = ($urandom_range(7) == 0) ? 8'($urandom) : pool[$urandom_range(40)];
      bus.letter_case     = 1'($urandom);
      bus.ascii_ready     = ((i / 100) % 2 == 0) ? ($urandom_range(3) != 0) : ($urandom_range(5) == 0);
      overflow_clr        = ($urandom_range(15) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/kbd_ascii_fifo.md
# kbd_ascii_fifo

Downstream stage of the PS/2 keyboard front end: samples each make-code pulse and its case flag from the keyboard FSM, translates the set-2 scan code to 7-bit ASCII in a registered lookup stage, and buffers characters in a first-word-fall-through FIFO. The consumer (UART TX, text console) drains it with a valid/ready handshake. Overflow is reported via a sticky flag.

## Interface
- DEPTH, 16: FIFO entries; power of two, ≥2. Local ADDR_W = $clog2(DEPTH).
- clk  in  1  system clock
- reset  in  1  reset, synchronous, active-high; clock clk
- scan_code  in  8  make code from keyboard FSM, valid only with scan_code_ready
- scan_code_ready  in  1  one-cycle pulse: sample scan_code/letter_case
- letter_case  in  1  0 lower/unshifted, 1 upper/shifted (shift or caps lock)
- ascii  out  8  head-of-FIFO character, bit 7 always 0
- ascii_valid  out  1  FIFO non-empty
- ascii_ready  in  1  consumer accepts head when ascii_valid
- level  out  ADDR_W+1  current occupancy, 0..DEPTH
- overflow  out  1  sticky: a character was dropped because FIFO was full
- overflow_clr  in  1  clears overflow

## Operation
- Lookup (combinational in kbd_pkg, result registered): letters 0x1C a,0x32 b,0x21 c,0x23 d,0x24 e,0x2B f,0x34 g,0x33 h,0x43 i,0x3B j,0x42 k,0x4B l,0x3A m,0x31 n,0x44 o,0x4D p,0x15 q,0x2D r,0x1B s,0x2C t,0x3C u,0x2A v,0x1D w,0x22 x,0x35 y,0x1A z → 0x61..0x7A lower, 0x41..0x5A upper.
- Digits 0x16,0x1E,0x26,0x25,0x2E,0x36,0x3D,0x3E,0x46,0x45 → '1'..'9','0'; upper → '!','@','#','$','%','^','&','*','(',')'.
- Case-independent: 0x29→0x20, 0x5A→0x0D, 0x66→0x08, 0x0D→0x09, 0x76→0x1B. All other codes → 0x00.
- Stage register: on scan_code_ready, capture ascii code and set stage_valid; stage_valid is a one-cycle pulse.
- FIFO write when stage_valid (subject to filter, see Configuration). Write refused when full and no same-cycle pop; refused write sets overflow.
- Pop when ascii_valid && ascii_ready. ascii/ascii_valid combinational from FIFO head and empty flag.
- Pointers ADDR_W+1 bits, wrap modulo 2·DEPTH; full = MSBs differ and low bits equal; empty = pointers equal; level = wr_ptr − rd_ptr.
- Full + simultaneous pop and write: both accepted, level stays DEPTH, no overflow.
- Empty + write: no same-cycle bypass; data visible next cycle.
- overflow set and overflow_clr same cycle: set wins.

## Timing
- Reset values: ascii 0x00, ascii_valid 0, level 0, overflow 0; stage register and pointers cleared.
- Latency: scan_code_ready at cycle N → stage register N+1 → ascii_valid at N+2 (FIFO empty).
- Throughput: one character per cycle in and out.
- Reset mid-operation discards stage and all FIFO contents within the same edge; a scan_code_ready coincident with reset is dropped.
- ascii must stay stable while ascii_valid && !ascii_ready.

## Configuration
- KBD_FILTER_NONPRINT_EN defined: stage entries with ascii 0x00 are not written and never set overflow.
- Undefined: 0x00 entries are written like any character (consumer sees unmapped keys as NUL).

## Structure
- kbd_pkg: scan-code localparams (keys, BREAK 0xF0, SHIFT 0x12/0x59, CAPS 0x58), function scan_to_ascii(code, upper) returning logic [7:0].
- Sub-module kbd_sync_fifo (parameter DEPTH, WIDTH=8): pointers, storage, full/empty/level, FWFT read; top holds lookup stage and overflow flag.

## Test plan
- Pulse 0x1C with letter_case=0, then 0x1C with 1 → ascii 0x61 at N+2, then 0x41; level 1→2, pops return in order.
- 0x16 with letter_case=1, 0x29, 0x5A → 0x21, 0x20, 0x0D.
- Code 0x07 → with macro: level stays 0; without: ascii 0x00 delivered.
- ascii_ready=0, write DEPTH+1 chars → level=DEPTH, overflow=1, first DEPTH chars intact; overflow_clr → 0.
- Full FIFO, ascii_ready=1 and new write same cycle → level stays DEPTH, overflow stays 0, order preserved.
- Reset asserted with 3 entries and a pending stage entry → next cycle ascii_valid=0, level=0, ascii=0x00.
